// File: rtl/mitchell_pkg.sv
// Shared types and helpers for the pipelined Mitchell multiplier.
// Stage structs are macros so each instance sizes them from its own localparams.
`ifndef MITCHELL_PKG_SV
`define MITCHELL_PKG_SV

`define MITCHELL_S1_T(KW_, F_, TW_) \
    typedef struct packed { \
        logic            valid; \
        logic [KW_-1:0]  ka; \
        logic [F_-1:0]   fa; \
        logic [KW_-1:0]  kb; \
        logic [F_-1:0]   fb; \
        logic            zero_any; \
        logic            sign; \
        logic [TW_-1:0]  tag; \
    } s1_t;

`define MITCHELL_S2_T(KW_, F_, TW_) \
    typedef struct packed { \
        logic            valid; \
        logic [F_:0]     m; \
        logic [KW_:0]    e; \
        logic            zero_any; \
        logic            sign; \
        logic [TW_-1:0]  tag; \
    } s2_t;

package mitchell_pkg;

    // Widest operand the shared helper supports.
    localparam int MAX_WIDTH = 64;

    function automatic logic [2*MAX_WIDTH-1:0] neg_if(input logic [2*MAX_WIDTH-1:0] x,
                                                      input logic                   s);
        return s ? -x : x;
    endfunction

endpackage

`endif

// File: rtl/mitchell_lod_norm.sv
// Leading-one detector and normaliser: mag = 2^k * (1 + f / 2^(WIDTH-1)).
module mitchell_lod_norm #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         mag,
    output logic [$clog2(WIDTH)-1:0] k,
    output logic [WIDTH-2:0]         f,
    output logic                     zero
);
    localparam int F  = WIDTH - 1;
    localparam int KW = $clog2(WIDTH);

    // NOTE: k gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) k = KW'(i);
        end
    end

    // Shifting the leading one up to bit F leaves the fraction in the bits below it.
    assign f    = F'(mag << (KW'(F) - k));
    assign zero = (mag == '0);

endmodule

// File: rtl/mitchell_mult_pipe.sv
// Three-stage pipelined Mitchell logarithmic multiplier with valid/ready on both
// sides and a sideband tag; a single global advance enable keeps bubbles in place.
module mitchell_mult_pipe
    import mitchell_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] p_o,
    output logic [TAG_W-1:0]   tag_o
);
    localparam int F  = WIDTH - 1;
    localparam int KW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam int XW = 2 * MAX_WIDTH;

    `MITCHELL_S1_T(KW, F, TAG_W)
    `MITCHELL_S2_T(KW, F, TAG_W)

    s1_t s1, s1_d;
    s2_t s2, s2_d;

    logic             adv;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [KW-1:0]    k_a, k_b;
    logic [F-1:0]     f_a, f_b;
    logic             zero_a, zero_b;
    logic [F:0]       f_sum;
    logic [PW-1:0]    mag_p;
    logic [PW-1:0]    p_d;

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    // S1: exact two's-complement magnitude, so the most negative operand maps to 2^(WIDTH-1).
    assign neg_a = signed_i & a_i[WIDTH-1];
    assign neg_b = signed_i & b_i[WIDTH-1];
    assign mag_a = WIDTH'(neg_if(XW'(a_i), neg_a));
    assign mag_b = WIDTH'(neg_if(XW'(b_i), neg_b));

    mitchell_lod_norm #(.WIDTH(WIDTH)) u_lod_a (
        .mag  (mag_a),
        .k    (k_a),
        .f    (f_a),
        .zero (zero_a)
    );

    mitchell_lod_norm #(.WIDTH(WIDTH)) u_lod_b (
        .mag  (mag_b),
        .k    (k_b),
        .f    (f_b),
        .zero (zero_b)
    );

    always_comb begin
        s1_d          = '0;
        s1_d.valid    = in_valid_i;
        s1_d.ka       = k_a;
        s1_d.fa       = f_a;
        s1_d.kb       = k_b;
        s1_d.fb       = f_b;
        s1_d.zero_any = zero_a | zero_b;
        s1_d.sign     = neg_a ^ neg_b;
        s1_d.tag      = tag_i;
    end

    // S2: a fraction carry doubles the mantissa's weight instead of adding the implicit one.
    always_comb begin
        f_sum         = {1'b0, s1.fa} + {1'b0, s1.fb};
        s2_d          = '0;
        s2_d.valid    = s1.valid;
        s2_d.m        = f_sum[F] ? f_sum : {1'b1, f_sum[F-1:0]};
        s2_d.e        = (KW+1)'(s1.ka) + (KW+1)'(s1.kb) + (KW+1)'(f_sum[F]);
        s2_d.zero_any = s1.zero_any;
        s2_d.sign     = s1.sign;
        s2_d.tag      = s1.tag;
    end

    // S3: antilog by shift, truncating toward zero; a zero operand forces +0.
    always_comb begin
        mag_p = PW'(((3*WIDTH)'(s2.m) << s2.e) >> F);
        p_d   = s2.zero_any ? '0 : PW'(neg_if(XW'(mag_p), s2.sign));
    end

    // NOTE: all stages, data included, clear on reset so p_o/tag_o read 0 and nothing stale survives.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1          <= '0;
            s2          <= '0;
            out_valid_o <= 1'b0;
            p_o         <= '0;
            tag_o       <= '0;
        end else if (adv) begin
            s1          <= s1_d;
            s2          <= s2_d;
            out_valid_o <= s2.valid;
            p_o         <= p_d;
            tag_o       <= s2.tag;
        end
    end

endmodule
